// File: rtl/lcd_line_buffer.sv
// Ping-pong two-line RGB565 buffer between a bursty pixel source and the LCD timing driver.
// The source fills one bank while the driver reads the other; pixel_data follows data_req by one cycle.
module lcd_line_buffer #(
  parameter int unsigned H_DISP_MAX = 1280,
  parameter int unsigned DATA_W     = 16
) (
  input  logic              lcd_clk,
  input  logic              sys_rst,
  input  logic [10:0]       h_disp,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic              data_req,
  input  logic [10:0]       pixel_xpos,
  input  logic [10:0]       pixel_ypos,
  output logic [DATA_W-1:0] pixel_data,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int unsigned MEM_D  = 2 * H_DISP_MAX;
  localparam int unsigned MEM_AW = $clog2(MEM_D);
  localparam logic [10:0] H_MAX  = 11'(H_DISP_MAX);

  localparam logic [1:0] B_EMPTY   = 2'd0;
  localparam logic [1:0] B_FILLING = 2'd1;
  localparam logic [1:0] B_FULL    = 2'd2;
  localparam logic [1:0] B_READING = 2'd3;

  localparam logic [0:0] W_FILL = 1'b0;
  localparam logic [0:0] W_WAIT = 1'b1;

  logic [DATA_W-1:0] mem [MEM_D];
  logic [DATA_W-1:0] rd_q;
  logic              rd_en;

  logic [1:0]  bank_st [2];
  logic [1:0]  tag;
  logic        wr_sel, rd_sel;
  logic [0:0]  wstate;
  logic [10:0] waddr, line_w;

  logic [10:0]       eff_w, cur_w, wa;
  logic              xfer, line_first, wr_last;
  logic [1:0]        rd_st;
  logic              line_start, drop, start_ok, rd_ok, line_end, uf_now;
  logic [MEM_AW-1:0] wmem, rmem;

  always_comb begin
    eff_w      = (h_disp != '0 && h_disp <= H_MAX) ? h_disp : H_MAX;
    in_ready   = !sys_rst && ((wstate == W_FILL)
                 ? (bank_st[wr_sel] == B_EMPTY || bank_st[wr_sel] == B_FILLING)
                 : (bank_st[wr_sel] == B_EMPTY));
    xfer       = in_valid && in_ready;
    // A sof pixel always restarts the line at address 0, abandoning any partial line.
    line_first = in_sof || (waddr == '0);
    cur_w      = line_first ? eff_w : line_w;
    wa         = in_sof ? '0 : waddr;
    wr_last    = (wa == cur_w - 11'd1);
    wmem       = wr_sel ? MEM_AW'(H_DISP_MAX) + MEM_AW'(wa) : MEM_AW'(wa);

    rd_st      = bank_st[rd_sel];
    line_start = data_req && (pixel_xpos == '0);
    drop       = (pixel_ypos == 11'd1) && !tag[rd_sel];
    start_ok   = line_start && (rd_st == B_FULL) && !drop;
    rd_ok      = data_req && (pixel_xpos < eff_w)
                 && (start_ok || (rd_st == B_READING && !line_start));
    line_end   = data_req && (pixel_xpos == eff_w - 11'd1)
                 && ((rd_st == B_READING && !line_start) || start_ok);
    uf_now     = line_start && !start_ok;
    rmem       = rd_sel ? MEM_AW'(H_DISP_MAX) + MEM_AW'(pixel_xpos) : MEM_AW'(pixel_xpos);
  end

  always_ff @(posedge lcd_clk) begin
    if (xfer) mem[wmem] <= in_data;
    if (rd_ok) rd_q <= mem[rmem];
  end

  assign pixel_data = rd_en ? rd_q : '0;

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      bank_st[0]    <= B_EMPTY;
      bank_st[1]    <= B_EMPTY;
      tag           <= '0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      wstate        <= W_FILL;
      waddr         <= '0;
      line_w        <= H_MAX;
      rd_en         <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (wstate == W_WAIT && bank_st[wr_sel] == B_EMPTY) wstate <= W_FILL;
      if (xfer) begin
        if (line_first) begin
          line_w      <= eff_w;
          tag[wr_sel] <= in_sof;
        end
        if (wr_last) begin
          bank_st[wr_sel] <= B_FULL;
          waddr           <= '0;
          wr_sel          <= ~wr_sel;
          if (bank_st[~wr_sel] != B_EMPTY) wstate <= W_WAIT;
        end else begin
          bank_st[wr_sel] <= B_FILLING;
          waddr           <= wa + 11'd1;
        end
      end
      // Reader only touches FULL/READING banks, the writer only EMPTY/FILLING ones.
      if (line_end) begin
        bank_st[rd_sel] <= B_EMPTY;
        rd_sel          <= ~rd_sel;
      end else if (line_start && rd_st == B_FULL && drop) begin
        bank_st[rd_sel] <= B_EMPTY;
      end else if (start_ok) begin
        bank_st[rd_sel] <= B_READING;
      end
      underflow <= uf_now;
      if (uf_now && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
      rd_en <= rd_ok;
    end
  end

endmodule
